// File: rtl/tqvp_gera_gray_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tqvp_gera_gray_tracker
// Purpose  : TinyQV peripheral that samples an absolute Gray-coded position on
//            ui_in[WIDTH-1:0], optionally debounces it, decodes it to binary
//            and tracks step direction, revolutions and skipped codes.
// Revision : 1.0 - initial release
//
// Parameters:
//   WIDTH    - Gray bits taken from ui_in (2..7; ui_in[7] is UART RX)
//   DEBOUNCE - consecutive stable cycles needed to accept a code (2..255)
//
// Build option:
//   GRAY_TRACK_DEBOUNCE_EN - when defined, a candidate/counter debouncer
//                            filters the input; otherwise any new code is
//                            accepted on the first edge it is sampled.
//
// Ports:
//   clk        - project clock
//   rst        - synchronous active-high reset
//   ui_in      - input PMOD (pre-synchronised), bits [WIDTH-1:0] used
//   uo_out     - {skip, dir, pos[5:0]}
//   address    - register select (0 POS, 1 GRAY, 2 REV, 3 STATUS)
//   data_write - single-cycle write strobe
//   data_in    - write data
//   data_out   - combinational read data
// ============================================================================
module tqvp_gera_gray_tracker #(
  parameter int WIDTH    = 6,
  parameter int DEBOUNCE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] STEP_UP   = WIDTH'(1);
  localparam logic [WIDTH-1:0] STEP_DOWN = '1;
  localparam logic [WIDTH-1:0] POS_MAX   = '1;
  localparam logic [WIDTH-1:0] POS_MIN   = '0;

  state_e           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] pos_q;
  logic [7:0]       rev_q;
  logic             dir_q;
  logic             moved_q;
  logic             skip_q;

  logic [WIDTH-1:0] sample_w;
  logic             accept_w;
  logic [WIDTH-1:0] new_code_w;
  logic [WIDTH-1:0] new_bin_w;
  logic [WIDTH-1:0] delta_w;
  logic             wr_rev_w;
  logic             wr_status_w;
  logic [5:0]       pos6_w;
  logic             unused_ui_w;

  assign sample_w    = ui_in[WIDTH-1:0];
  assign unused_ui_w = ^ui_in;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

`ifdef GRAY_TRACK_DEBOUNCE_EN
  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE - 1);

  logic [WIDTH-1:0] cand_q;
  logic [7:0]       cnt_q;

  // The counter saturates at CNT_LAST so a code held indefinitely stays
  // eligible; acceptance is then gated by cand != acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else if (sample_w != cand_q) begin
      cand_q <= sample_w;
      cnt_q  <= '0;
    end else if (cnt_q < CNT_LAST) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign accept_w   = (sample_w == cand_q) && (cnt_q == CNT_LAST) && (cand_q != acc_q);
  assign new_code_w = cand_q;
`else
  logic [31:0] unused_debounce_w;
  assign unused_debounce_w = 32'(DEBOUNCE);

  assign accept_w   = (sample_w != acc_q);
  assign new_code_w = sample_w;
`endif

  assign new_bin_w   = gray2bin(new_code_w);
  assign delta_w     = new_bin_w - pos_q;
  assign wr_rev_w    = data_write && (address == 4'h2);
  assign wr_status_w = data_write && (address == 4'h3);

  // Clears are applied first and event updates afterwards so that a flag set
  // in the same cycle wins over W1C; the REV write is applied last so it wins
  // over a wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      acc_q   <= '0;
      pos_q   <= '0;
      rev_q   <= '0;
      dir_q   <= 1'b0;
      moved_q <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      if (wr_status_w) begin
        if (data_in[0]) dir_q   <= 1'b0;
        if (data_in[1]) moved_q <= 1'b0;
        if (data_in[2]) skip_q  <= 1'b0;
      end

      if (accept_w) begin
        acc_q <= new_code_w;
        pos_q <= new_bin_w;
        case (state_q)
          ST_INIT: begin
            state_q <= ST_TRACK;
          end
          default: begin
            moved_q <= 1'b1;
            if (delta_w == STEP_UP) begin
              dir_q <= 1'b1;
              if (pos_q == POS_MAX) rev_q <= rev_q + 8'd1;
            end else if (delta_w == STEP_DOWN) begin
              dir_q <= 1'b0;
              if (pos_q == POS_MIN) rev_q <= rev_q - 8'd1;
            end else begin
              skip_q <= 1'b1;
            end
          end
        endcase
      end

      if (wr_rev_w) rev_q <= data_in;
    end
  end

  // Zero-extend narrow positions, truncate a 7-bit one to the 6 output bits.
  assign pos6_w = 6'(pos_q);
  assign uo_out = {skip_q, dir_q, pos6_w};

  always_comb begin
    data_out = 8'h00;
    case (address)
      4'h0:    data_out = 8'(pos_q);
      4'h1:    data_out = 8'(acc_q);
      4'h2:    data_out = rev_q;
      4'h3:    data_out = {5'b00000, skip_q, moved_q, dir_q};
      default: data_out = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tqvp_gera_gray_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_tqvp_gera_gray_tracker
// Purpose  : Self-checking bench for tqvp_gera_gray_tracker (WIDTH=6,
//            DEBOUNCE=4). Directed scenarios plus randomised stimulus checked
//            against a behavioural model built from a Gray lookup table and
//            a run-length view of the input history.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tqvp_gera_gray_tracker;

  localparam int W    = 6;
  localparam int DB   = 4;
  localparam int NPOS = 1 << W;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uo_out;
  logic [3:0] address = 4'h0;
  logic       data_write = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  tqvp_gera_gray_tracker #(
    .WIDTH    (W),
    .DEBOUNCE (DB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int gray_of [NPOS];
  int m_last, m_run, m_pos, m_acc, m_rev;
  bit m_init, m_dir, m_moved, m_skip;

  function automatic int to_bin(input int g);
    for (int b = 0; b < NPOS; b++) if (gray_of[b] == g) return b;
    return 0;
  endfunction

  task automatic model_reset();
    m_last = 0; m_run = 1; m_init = 1'b1;
    m_pos = 0; m_acc = 0; m_rev = 0;
    m_dir = 1'b0; m_moved = 1'b0; m_skip = 1'b0;
  endtask

  // Apply one rising edge to the model using the inputs currently driven.
  task automatic model_edge();
    int s, nb, d;
    bit take;
    if (rst) begin
      model_reset();
      return;
    end
    s = int'(ui_in) % NPOS;
`ifdef GRAY_TRACK_DEBOUNCE_EN
    // A code is accepted once it has been seen on DB+1 consecutive edges.
    if (s == m_last) m_run = (m_run < DB + 1) ? m_run + 1 : m_run;
    else begin m_last = s; m_run = 1; end
    take = (m_run == DB + 1) && (s != m_acc);
`else
    take = (s != m_acc);
`endif
    if (data_write && address == 4'h3) begin
      if (data_in[0]) m_dir = 1'b0;
      if (data_in[1]) m_moved = 1'b0;
      if (data_in[2]) m_skip = 1'b0;
    end
    if (take) begin
      nb = to_bin(s);
      if (m_init) begin
        m_init = 1'b0;
      end else begin
        d = (nb - m_pos + NPOS) % NPOS;
        if (d == 1) begin
          m_dir = 1'b1;
          if (m_pos == NPOS - 1) m_rev = (m_rev + 1) % 256;
        end else if (d == NPOS - 1) begin
          m_dir = 1'b0;
          if (m_pos == 0) m_rev = (m_rev + 255) % 256;
        end else begin
          m_skip = 1'b1;
        end
        m_moved = 1'b1;
      end
      m_acc = s;
      m_pos = nb;
    end
    if (data_write && address == 4'h2) m_rev = int'(data_in);
  endtask

  function automatic logic [7:0] exp_uo();
    return {m_skip, m_dir, 6'(m_pos)};
  endfunction

  function automatic logic [7:0] exp_reg(input int a);
    case (a)
      0:       return 8'(m_pos);
      1:       return 8'(m_acc);
      2:       return 8'(m_rev);
      3:       return {5'b00000, m_skip, m_moved, m_dir};
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [7:0] ui, input bit wr, input logic [3:0] a, input logic [7:0] din);
    ui_in = ui; data_write = wr; address = a; data_in = din;
    @(posedge clk);
    model_edge();
    #1;
    data_write = 1'b0;
    check_eq("uo_out", uo_out, exp_uo());
  endtask

  task automatic hold(input logic [7:0] ui, input int n);
    for (int k = 0; k < n; k++) cyc(ui, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic do_reset(input logic [7:0] ui);
    rst = 1'b1;
    cyc(ui, 1'b0, 4'h0, 8'h00);
    rst = 1'b0;
  endtask

  task automatic expect_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    address = a;
    #1;
    check_eq(tag, data_out, exp);
  endtask

  task automatic read_all();
    for (int a = 0; a < 4; a++) begin
      address = 4'(a);
      #1;
      check_eq($sformatf("reg%0d", a), data_out, exp_reg(a));
    end
    address = 4'($urandom_range(4, 15));
    #1;
    check_eq("unmapped", data_out, 8'h00);
  endtask

  initial begin
    for (int b = 0; b < NPOS; b++) gray_of[b] = b ^ (b >> 1);
    model_reset();
    @(negedge clk);

    // Reset with 0x07 held through it.
    do_reset(8'h07);
    check_eq("rst_uo", uo_out, 8'h00);
    expect_reg("rst_pos", 4'h0, 8'h00);
    expect_reg("rst_stat", 4'h3, 8'h00);
    expect_reg("rst_rev", 4'h2, 8'h00);
    @(negedge clk);

`ifdef GRAY_TRACK_DEBOUNCE_EN
    hold(8'h07, DB);
    expect_reg("tp1_early", 4'h0, 8'h00);
    @(negedge clk);
    hold(8'h07, 1);
    check_eq("tp1_uo", uo_out, 8'h05);
    expect_reg("tp1_pos", 4'h0, 8'h05);
    expect_reg("tp1_gray", 4'h1, 8'h07);
    expect_reg("tp1_stat", 4'h3, 8'h00);
    @(negedge clk);

    hold(8'h05, DB + 1);
    check_eq("tp2_uo", uo_out, 8'h46);
    expect_reg("tp2_stat", 4'h3, 8'h03);
    @(negedge clk);
    cyc(8'h05, 1'b1, 4'h3, 8'h02);
    expect_reg("tp2_w1c", 4'h3, 8'h01);
    @(negedge clk);

    do_reset(8'h20);
    hold(8'h20, DB + 1);
    expect_reg("tp3_init", 4'h0, 8'h3F);
    @(negedge clk);
    hold(8'h00, DB + 1);
    check_eq("tp3_up_uo", uo_out, 8'h40);
    expect_reg("tp3_up_rev", 4'h2, 8'h01);
    @(negedge clk);
    hold(8'h20, DB + 1);
    check_eq("tp3_dn_uo", uo_out, 8'h3F);
    expect_reg("tp3_dn_rev", 4'h2, 8'h00);
    @(negedge clk);
    // REV write collides with an upward wrap: the write must win.
    hold(8'h00, DB);
    cyc(8'h00, 1'b1, 4'h2, 8'h55);
    expect_reg("tp3_wr_rev", 4'h2, 8'h55);
    @(negedge clk);

    do_reset(8'h07);
    hold(8'h07, DB + 1);
    hold(8'h05, DB - 1);
    hold(8'h07, DB + 2);
    expect_reg("tp4_pos", 4'h0, 8'h05);
    expect_reg("tp4_stat", 4'h3, 8'h00);
    @(negedge clk);

    hold(8'h0D, DB + 1);
    check_eq("tp5_uo", uo_out, 8'h89);
    expect_reg("tp5_stat", 4'h3, 8'h06);
    expect_reg("tp5_rev", 4'h2, 8'h00);
    @(negedge clk);
    // Skip to binary 20 (Gray 0x1E) while clearing skip in the same cycle.
    for (int k = 0; k <= DB; k++) cyc(8'h1E, (k == DB), 4'h3, 8'h04);
    expect_reg("tp5_set_wins", 4'h3, 8'h06);
    expect_reg("tp5_pos", 4'h0, 8'h14);
    @(negedge clk);
`else
    hold(8'h07, 1);
    expect_reg("nd_init", 4'h0, 8'h05);
    @(negedge clk);
    hold(8'h05, 1);
    expect_reg("nd_up", 4'h0, 8'h06);
    @(negedge clk);
    hold(8'h07, 1);
    check_eq("nd_dn_uo", uo_out, 8'h05);
    expect_reg("nd_dn_stat", 4'h3, 8'h02);
    @(negedge clk);
`endif

    // Randomised segments: mostly single steps, some jumps and short glitches,
    // random register writes and occasional resets.
    for (int seg = 0; seg < 400; seg++) begin
      int r, tgt, len;
      r = $urandom_range(0, 99);
      if (r < 70)      tgt = (m_pos + (($urandom_range(0, 1) == 1) ? 1 : NPOS - 1)) % NPOS;
      else if (r < 90) tgt = $urandom_range(0, NPOS - 1);
      else             tgt = m_pos;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        bit          wr;
        logic [3:0]  wa;
        wr = ($urandom_range(0, 9) == 0);
        wa = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(2, 3));
        rst = ($urandom_range(0, 299) == 0);
        cyc({2'($urandom), 6'(gray_of[tgt])}, wr, wa, 8'($urandom));
        rst = 1'b0;
        read_all();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tqvp_gera_gray_tracker.md
# tqvp_gera_gray_tracker

Gray-code input tracker peripheral for the TinyQV core: the receive-side counterpart of the team's Gray coder. It samples an absolute Gray-coded position (e.g. a mechanical absolute encoder) on `ui_in`, debounces it, decodes it to binary, and tracks direction, revolutions and skipped codes. All results are register-readable and mirrored on `uo_out`.

## Interface
Parameters:
- `WIDTH`, 6: Gray bits taken from `ui_in[WIDTH-1:0]`; legal range 2..7, since `ui_in[7]` is reserved for UART RX.
- `DEBOUNCE`, 16: consecutive stable cycles required to accept a code; legal range 2..255.

Ports:
- `clk`  in  1  project clock (64 MHz nominal).
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `ui_in`  in  8  input PMOD, already synchronized by the wrapper; only bits `[WIDTH-1:0]` are used.
- `uo_out`  out  8  `{skip, dir, pos[5:0]}`; `pos` is zero-extended, or truncated to 6 bits when `WIDTH` is 7.
- `address`  in  4  register select.
- `data_write`  in  1  write strobe, single cycle.
- `data_in`  in  8  write data.
- `data_out`  out  8  read data; combinational from `address`.

## Operation
Register map (reads zero-extended; unmapped addresses read 0 and ignore writes):
- 0x0 POS, RO: binary position `pos`.
- 0x1 GRAY, RO: accepted Gray code `acc`.
- 0x2 REV, RW: 8-bit revolution counter, wraps modulo 256. A write loads `data_in`.
- 0x3 STATUS, write-1-to-clear.
  - bit0 `dir`: last step direction, 1 = up.
  - bit1 `moved`: sticky, set on any accepted change.
  - bit2 `skip`: sticky, set when an accepted change is not ±1.
  - Bits 7:3 read 0.

Debounce (sample `s = ui_in[WIDTH-1:0]`, candidate `cand`, counter `cnt`):
- `s != cand`: `cand <= s`, `cnt <= 0`.
- Else if `cnt < DEBOUNCE-1`: `cnt <= cnt+1`.
- Else, if `cand != acc`: accept `cand`. `cnt` saturates.

State machine:
- INIT, entered on reset: the first acceptance loads `acc`/`pos` only. No flags change and REV is untouched. Then go to TRACK.
- TRACK: on each acceptance, `new = gray2bin(cand)` and `d = new - pos` (mod 2^WIDTH).
  - `d == 1`: `dir <= 1`. If `pos` was all-ones, `REV <= REV+1`.
  - `d == all-ones` (-1): `dir <= 0`. If `pos` was 0, `REV <= REV-1`.
  - Any other `d`: `skip <= 1`; `dir` and REV unchanged.
  - In all cases `acc <= cand`, `pos <= new`, `moved <= 1`.
- Gray decode: `bin[W-1] = g[W-1]`; `bin[i] = g[i] ^ bin[i+1]`.

## Timing
- Reset values: POS = 0, GRAY = 0, REV = 0, STATUS = 0, `cand` = 0, `cnt` = 0, state INIT. Hence `uo_out` = 0x00 and `data_out` = 0x00 after reset.
- Acceptance latency: a value first present on `ui_in` at rising edge e0, and held, is accepted at edge e(DEBOUNCE). POS/GRAY/STATUS/REV are visible after that edge.
- A glitch shorter than DEBOUNCE cycles is never accepted.
- `rst` asserted mid-debounce or mid-step discards all state and returns to INIT.
- Write/event collision in the same cycle:
  - STATUS clear vs. flag set: the set wins.
  - REV write vs. wrap: the write wins.
- Reads have no side effects.

## Configuration
- `GRAY_TRACK_DEBOUNCE_EN` defined: the debounce path is built as described above, honouring `DEBOUNCE`.
- Not defined:
  - `cand`/`cnt` logic is removed and `DEBOUNCE` is ignored.
  - Any `s != acc` is accepted at the first edge (e0), with identical INIT/TRACK semantics.

## Test plan
Default parameters are WIDTH=6 and DEBOUNCE=4, with the macro defined.
- Hold `ui_in = 0x07` through and after reset → at edge e4, POS=5, GRAY=0x07, REV=0, STATUS=0x00, `uo_out=0x05`.
- From POS=5, apply 0x05 (gray 6) → POS=6, STATUS=0x03, `uo_out=0x46`. Then write 0x02 to 0x3 → STATUS=0x01.
- Wrap up, then back:
  - From gray 0x20 (POS=63), apply 0x00 → POS=0, REV=1, `dir=1`.
  - Re-apply 0x20 → POS=63, REV=0, `dir=0`.
- From POS=5 (0x07), pulse `ui_in = 0x05` for 3 cycles, then return to 0x07 → POS stays 5 and STATUS stays 0x00.
- From POS=5, apply 0x0D (gray 9) → POS=9, STATUS bit2=1, REV unchanged, `uo_out[7]=1`. Then write 0x04 to 0x3 in the same cycle as a new skip event → `skip` stays 1.
- Macro undefined: a 1-cycle pulse to 0x05 from 0x07 → POS=6 after e0, then POS=5 after the next edge, with `dir=0`.
